// File: rtl/wb_store_buffer_if.sv
// wb_store_buffer_if: writeback store, dcache write and load probe signals of the store buffer
// slave  - store buffer side (accepts WB stores, drives the dcache write port, answers load probes)
// master - environment side (writeback stage, dcache and memory stage)
interface wb_store_buffer_if;
  logic        WB_Dcache_Write;
  logic [31:0] WB_Dcache_Address;
  logic [63:0] WB_Dcache_Data;
  logic [1:0]  WB_Dcache_Size;
  logic        In_write_ready;
  logic        DC_WR_REQ;
  logic [31:0] DC_WR_ADDR;
  logic [63:0] DC_WR_DATA;
  logic [1:0]  DC_WR_SIZE;
  logic        DC_WR_ACK;
  logic [31:0] LD_ADDR;
  logic        LD_CONFLICT;
  logic        SB_EMPTY;
  modport slave (
    input  WB_Dcache_Write, WB_Dcache_Address, WB_Dcache_Data, WB_Dcache_Size, DC_WR_ACK, LD_ADDR,
    output In_write_ready, DC_WR_REQ, DC_WR_ADDR, DC_WR_DATA, DC_WR_SIZE, LD_CONFLICT, SB_EMPTY
  );
  modport master (
    output WB_Dcache_Write, WB_Dcache_Address, WB_Dcache_Data, WB_Dcache_Size, DC_WR_ACK, LD_ADDR,
    input  In_write_ready, DC_WR_REQ, DC_WR_ADDR, DC_WR_DATA, DC_WR_SIZE, LD_CONFLICT, SB_EMPTY
  );
endinterface

// File: rtl/wb_store_buffer.sv
// wb_store_buffer: in-order FIFO store buffer between writeback and the dcache write port
// CLK - pipeline clock; CLR - asynchronous active-low reset
// sb  - store interface: WB store in / In_write_ready, DC_WR req/ack drain, LD_ADDR overlap probe, SB_EMPTY
module wb_store_buffer #(
  parameter int DEPTH = 4
) (
  input logic             CLK,
  input logic             CLR,
  wb_store_buffer_if.slave sb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0]   addr_q [DEPTH];
  logic [63:0]   data_q [DEPTH];
  logic [1:0]    size_q [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic          enq, deq;
  assign sb.In_write_ready = count != FULL;
  assign sb.DC_WR_REQ      = count != '0;
  assign sb.SB_EMPTY       = count == '0;
  assign sb.DC_WR_ADDR     = addr_q[head];
  assign sb.DC_WR_DATA     = data_q[head];
  assign sb.DC_WR_SIZE     = size_q[head];
  assign enq = sb.WB_Dcache_Write && sb.In_write_ready;
  assign deq = sb.DC_WR_REQ && sb.DC_WR_ACK;
  // entry j is live when its distance from head (mod DEPTH) is below count
  always_comb begin
    sb.LD_CONFLICT = 1'b0;
    for (int j = 0; j < DEPTH; j++)
      if ({1'b0, AW'(j) - head} < count && addr_q[j][31:3] == sb.LD_ADDR[31:3])
        sb.LD_CONFLICT = 1'b1;
  end
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        addr_q[j] <= '0;
        data_q[j] <= '0;
        size_q[j] <= '0;
      end
    end else begin
      if (enq) begin
        addr_q[tail] <= sb.WB_Dcache_Address;
        data_q[tail] <= sb.WB_Dcache_Data;
        size_q[tail] <= sb.WB_Dcache_Size;
        tail         <= tail + 1'b1;
      end
      if (deq) head <= head + 1'b1;
      count <= count + {AW'(0), enq} - {AW'(0), deq};
    end
  end
endmodule
